// File: rtl/adc_rx.sv
// SPI mode-0 read master for the bolometer ADC: on request, drops CS, clocks in one
// MSB-first word on rising SCLK edges and presents it with a one-cycle valid strobe.
module adc_rx #(
   parameter int DATA_WIDTH = 12,
   parameter int CLK_DIV    = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic                  miso_i,
   output logic                  cs_o,
   output logic                  sclk_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   output logic                  busy_o,
   output logic [1:0]            dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(CLK_DIV - 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  cs_q, cs_d;
   logic                  sclk_q, sclk_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;

   // Outputs are computed for the next state and registered, so each output
   // changes on the same edge as the state it belongs to.
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      cs_d    = cs_q;
      sclk_d  = sclk_q;
      valid_d = 1'b0;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            cs_d   = 1'b1;
            sclk_d = 1'b0;
            busy_d = 1'b0;
            div_d  = '0;
            bit_d  = '0;
            if (start_i) begin
               state_d = SETUP;
               cs_d    = 1'b0;
               busy_d  = 1'b1;
            end
         end
         SETUP: begin
            if (div_q == LAST_DIV) begin
               state_d = SHIFT;
               div_d   = '0;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         SHIFT: begin
            if (div_q == LAST_DIV) begin
               div_d = '0;
               // The edge that raises SCLK is the one that samples MISO.
               if (!sclk_q) begin
                  sclk_d  = 1'b1;
                  shift_d = (shift_q << 1) | DATA_WIDTH'(miso_i);
               end else begin
                  sclk_d = 1'b0;
                  bit_d  = bit_q + 1'b1;
                  if (bit_q == LAST_BIT) begin
                     state_d = DONE;
                     cs_d    = 1'b1;
                     valid_d = 1'b1;
                     data_d  = shift_q;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         cs_q    <= 1'b1;
         sclk_q  <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         cs_q    <= cs_d;
         sclk_q  <= sclk_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign cs_o        = cs_q;
   assign sclk_o      = sclk_q;
   assign data_o      = data_q;
   assign valid_o     = valid_q;
   assign busy_o      = busy_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_adc_rx.sv
// Bench for adc_rx: two instances (12-bit / divide-by-4 and 4-bit / divide-by-1), each
// with an ADC pin model, a start driver and a monitor popping an expected-word queue.
module tb_adc_rx;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int pass_cnt = 0;
   int chk_cnt  = 0;
   bit done_flag [2];

   task automatic check(input int inst, input bit ok, input string name,
                        input int act, input int exp);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL dut%0d %s: got %0h, expected %0h (cycle %0d)",
                    inst, name, act, exp, cyc + 1);
   endtask

   // A cycle number t names the clock period that follows edge t-1; outputs are sampled
   // on the falling edge, where that period is cyc + 1.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      localparam int CD    = (g == 0) ? 4 : 1;
      localparam int W     = (g == 0) ? 12 : 4;
      localparam int LAT   = CD + 2 * CD * W + 1;
      localparam int ABORT = (2 * LAT) / 5;
      localparam logic [W-1:0] FIX_WORD = (g == 0) ? W'(12'hA5C) : W'(4'b1001);

      logic         rst;
      logic         start;
      logic         miso;
      logic         cs;
      logic         sclk;
      logic         valid;
      logic         busy;
      logic [W-1:0] data;
      logic [1:0]   dbg;
      bit           gap_chk;

      logic [W-1:0] exp_q[$];
      int           exp_cyc_q[$];
      int           start_q[$];
      logic [W-1:0] adc_q[$];

      adc_rx #(.DATA_WIDTH(W), .CLK_DIV(CD)) u_dut (
         .clk_i      (clk),
         .rst_i      (rst),
         .start_i    (start),
         .miso_i     (miso),
         .cs_o       (cs),
         .sclk_o     (sclk),
         .data_o     (data),
         .valid_o    (valid),
         .busy_o     (busy),
         .dbg_state_o(dbg)
      );

      // One request; with_valid=0 means the transfer will be aborted by reset.
      task automatic issue(input logic [W-1:0] word, input bit with_valid);
         int n;
         start = 1'b1;
         n = cyc + 1;
         start_q.push_back(n);
         adc_q.push_back(word);
         if (with_valid) begin
            exp_q.push_back(word);
            exp_cyc_q.push_back(n + LAT);
         end
         @(negedge clk);
         start = 1'b0;
      endtask

      task automatic check_reset_values(input string tag);
         check(g, cs == 1'b1, {tag, "_cs"}, int'(cs), 1);
         check(g, sclk == 1'b0, {tag, "_sclk"}, int'(sclk), 0);
         check(g, data == '0, {tag, "_data"}, int'(data), 0);
         check(g, valid == 1'b0, {tag, "_valid"}, int'(valid), 0);
         check(g, busy == 1'b0, {tag, "_busy"}, int'(busy), 0);
         check(g, dbg == 2'd0, {tag, "_state"}, int'(dbg), 0);
      endtask

      // ADC pin model plus protocol monitor and scoreboard.
      initial begin
         bit           prev_cs = 1'b1;
         bit           prev_sclk = 1'b0;
         bit           after_valid = 1'b0;
         int           run_len = 0;
         int           rises = 0;
         int           cur_n = 0;
         int           cs_high_len = 0;
         int           bit_idx = 0;
         int           t;
         logic [W-1:0] adc_word = '0;
         logic [W-1:0] e;
         int           ec;
         miso = 1'b0;
         forever begin
            @(negedge clk);
            t = cyc + 1;
            if (rst) begin
               rises = 0;
               run_len = 0;
               after_valid = 1'b0;
               cs_high_len = 0;
            end else begin
               if (prev_cs && !cs) begin
                  check(g, start_q.size() > 0, "cs_fall_expected", 0, 1);
                  if (start_q.size() > 0) begin
                     cur_n = start_q.pop_front();
                     check(g, t == cur_n + 1, "cs_fall_cycle", t, cur_n + 1);
                  end
                  if (gap_chk) check(g, cs_high_len == 2, "cs_high_gap", cs_high_len, 2);
                  adc_word = (adc_q.size() > 0) ? adc_q.pop_front() : '0;
                  bit_idx = W - 1;
                  miso = adc_word[bit_idx];
                  rises = 0;
               end
               if (cs) cs_high_len = (!prev_cs) ? 1 : cs_high_len + 1;

               if (!prev_sclk && sclk) begin
                  rises++;
                  check(g, !cs, "sclk_rise_cs_low", int'(cs), 0);
                  // Setup phase plus the low half of the first bit precede the first rise.
                  if (rises == 1)
                     check(g, t == cur_n + 2 * CD + 1, "first_rise", t, cur_n + 2 * CD + 1);
                  else
                     check(g, run_len == CD, "sclk_low_len", run_len, CD);
                  run_len = 1;
               end else if (prev_sclk && !sclk) begin
                  check(g, run_len == CD, "sclk_high_len", run_len, CD);
                  if (bit_idx > 0) bit_idx--;
                  miso = adc_word[bit_idx];
                  run_len = 1;
               end else begin
                  run_len++;
               end

               if (valid) begin
                  check(g, exp_q.size() > 0, "valid_expected", 1, 0);
                  if (exp_q.size() > 0) begin
                     e = exp_q.pop_front();
                     ec = exp_cyc_q.pop_front();
                     check(g, data == e, "data", int'(data), int'(e));
                     check(g, t == ec, "valid_cycle", t, ec);
                     check(g, rises == W, "rise_count", rises, W);
                     check(g, cs == 1'b1, "cs_in_done", int'(cs), 1);
                     check(g, busy == 1'b1, "busy_in_done", int'(busy), 1);
                  end
                  after_valid = 1'b1;
               end else if (after_valid) begin
                  check(g, busy == 1'b0, "busy_after_done", int'(busy), 0);
                  after_valid = 1'b0;
               end
            end
            prev_cs = cs;
            prev_sclk = sclk;
         end
      end

      // Stimulus program.
      initial begin
         int n;
         int r;
         rst = 1'b1;
         start = 1'b0;
         gap_chk = 1'b0;
         repeat (3) @(negedge clk);
         rst = 1'b0;
         repeat (3) @(negedge clk);

         rst = 1'b1;
         repeat (2) @(negedge clk);
         check_reset_values("idle_reset");
         rst = 1'b0;
         @(negedge clk);

         // Known word, with an ignored start pulse in the middle of the transfer.
         issue(FIX_WORD, 1'b1);
         repeat (LAT / 2 - 1) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (LAT) @(negedge clk);

         // Back-to-back with start held: all ones then all zeros.
         start = 1'b1;
         n = cyc + 1;
         start_q.push_back(n);
         start_q.push_back(n + LAT + 1);
         adc_q.push_back('1);
         adc_q.push_back('0);
         exp_q.push_back('1);
         exp_q.push_back('0);
         exp_cyc_q.push_back(n + LAT);
         exp_cyc_q.push_back(n + 2 * LAT + 1);
         repeat (LAT) @(negedge clk);
         gap_chk = 1'b1;
         repeat (2) @(negedge clk);
         start = 1'b0;
         repeat (LAT + 3) @(negedge clk);
         gap_chk = 1'b0;

         // Reset in the middle of a transfer discards the word.
         issue(W'($urandom) | W'(1), 1'b0);
         repeat (ABORT - 1) @(negedge clk);
         rst = 1'b1;
         @(negedge clk);
         check_reset_values("abort_reset");
         rst = 1'b0;
         @(negedge clk);
         issue(FIX_WORD, 1'b1);
         repeat (LAT + 2) @(negedge clk);

         // Random words, random idle gaps and ignored start pulses.
         for (int i = 0; i < 6; i++) begin
            issue(W'($urandom), 1'b1);
            r = $urandom_range(1, LAT - 2);
            repeat (r) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (LAT - r + $urandom_range(0, 3)) @(negedge clk);
         end

         repeat (5) @(negedge clk);
         check(g, exp_q.size() == 0, "missing_valid", exp_q.size(), 0);
         done_flag[g] = 1'b1;
      end
   end

   initial begin
      bit timed_out = 1'b1;
      for (int i = 0; i < 20000; i++) begin
         @(negedge clk);
         if (done_flag[0] && done_flag[1]) begin
            timed_out = 1'b0;
            break;
         end
      end
      if (timed_out) begin
         chk_cnt++;
         $display("FAIL timeout: stimulus programs did not finish, got %0d/%0d done, expected 2/2",
                  int'(done_flag[0]) + int'(done_flag[1]), 2);
      end
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
